// File: rtl/otter_dcache_if.sv
// ============================================================================
// otter_dcache_if : core data-port and backing-memory signals of otter_dcache
// Revision: 1.0
// ============================================================================
`default_nettype none

interface otter_dcache_if;
   logic        MEM_RDEN2;
   logic        MEM_WE2;
   logic [31:0] MEM_ADDR2;
   logic [31:0] MEM_DIN2;
   logic [1:0]  MEM_SIZE;
   logic        MEM_SIGN;
   logic [31:0] MEM_DOUT2;
   logic        memValid2;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
      output MEM_DOUT2, memValid2,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN,
      input  MEM_DOUT2, memValid2,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

`default_nettype wire

// File: rtl/otter_dcache.sv
// ============================================================================
// otter_dcache : write-back direct-mapped data cache with req/ack refill port.
// Optional hit/miss counters enabled by macro DCACHE_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module otter_dcache #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  wire logic       CLK,
   input  wire logic       RESET,
   otter_dcache_if.slave   bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count
`endif
);

   localparam int WB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TB = 30 - WB - IB;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WB    = 2'd1,
      S_ALLOC = 2'd2
   } state_t;

   state_t              r_state, w_next;
   logic [WB-1:0]       r_cnt;
   logic [IB-1:0]       r_idx;
   logic [TB-1:0]       r_mtag;
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;
   logic [TB-1:0]       r_tag  [LINES];
   logic [31:0]         r_data [LINES][WORDS];

   logic [1:0]          w_off;
   logic [WB-1:0]       w_word;
   logic [IB-1:0]       w_idx;
   logic [TB-1:0]       w_tag;
   logic                w_req, w_load, w_hit, w_last, w_ack;
   logic [31:0]         w_rword, w_ext, w_wdata;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [3:0]          w_be;
   logic                w_mem_req, w_mem_we, w_valid_out;
   logic [31:0]         w_mem_addr, w_mem_wdata;

   assign w_off  = bus.MEM_ADDR2[1:0];
   assign w_word = bus.MEM_ADDR2[2 +: WB];
   assign w_idx  = bus.MEM_ADDR2[2 + WB +: IB];
   assign w_tag  = bus.MEM_ADDR2[2 + WB + IB +: TB];
   assign w_req  = bus.MEM_WE2 | bus.MEM_RDEN2;
   assign w_load = bus.MEM_RDEN2 & ~bus.MEM_WE2;
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_last = (r_cnt == WB'(WORDS - 1));
   assign w_ack  = bus.mem_ack & w_mem_req;

   // Load extraction and sign/zero extension
   always_comb begin
      w_rword = r_data[w_idx][w_word];
      w_byte  = w_rword[{w_off, 3'b000} +: 8];
      w_half  = bus.MEM_ADDR2[1] ? w_rword[31:16] : w_rword[15:0];
      case (bus.MEM_SIZE)
         2'd0:    w_ext = bus.MEM_SIGN ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'd1:    w_ext = bus.MEM_SIGN ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ext = w_rword;
      endcase
   end

   // Store data replicated across lanes so the byte enables pick the right copy
   always_comb begin
      case (bus.MEM_SIZE)
         2'd0: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{bus.MEM_DIN2[7:0]}};
         end
         2'd1: begin
            w_be    = bus.MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.MEM_DIN2[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = bus.MEM_DIN2;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = 32'd0;
      w_mem_wdata = 32'd0;
      w_valid_out = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_req && !w_hit) begin
               w_valid_out = 1'b0;
               w_next      = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_ALLOC;
            end
         end
         S_WB: begin
            w_valid_out = 1'b0;
            w_mem_req   = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = {r_tag[r_idx], r_idx, r_cnt, 2'b00};
            w_mem_wdata = r_data[r_idx][r_cnt];
            if (bus.mem_ack && w_last) w_next = S_ALLOC;
         end
         S_ALLOC: begin
            w_valid_out = 1'b0;
            w_mem_req   = 1'b1;
            w_mem_addr  = {r_mtag, r_idx, r_cnt, 2'b00};
            if (bus.mem_ack && w_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Miss address is captured so a dropped request still finishes its refill
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_mtag  <= '0;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req && !w_hit) begin
                  r_idx  <= w_idx;
                  r_mtag <= w_tag;
                  r_cnt  <= '0;
               end else if (bus.MEM_WE2 && w_hit) begin
                  r_dirty[w_idx] <= 1'b1;
               end
            end
            S_WB: begin
               if (w_ack) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) r_dirty[r_idx] <= 1'b0;
               end
            end
            S_ALLOC: begin
               if (w_ack) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) r_valid[r_idx] <= 1'b1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == S_IDLE && bus.MEM_WE2 && w_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_data[w_idx][w_word][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
      if (r_state == S_ALLOC && w_ack) begin
         r_data[r_idx][r_cnt] <= bus.mem_rdata;
         if (w_last) r_tag[r_idx] <= r_mtag;
      end
   end

   assign bus.memValid2 = w_valid_out;
   assign bus.MEM_DOUT2 = (r_state == S_IDLE && w_load && w_hit) ? w_ext : 32'd0;
   assign bus.mem_req   = w_mem_req;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;
   logic        r_after_miss;

   // The hit that follows a refill belongs to the miss, not to hit_count
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_hit_cnt    <= 32'd0;
         r_miss_cnt   <= 32'd0;
         r_after_miss <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_req && w_hit && !r_after_miss && r_hit_cnt != 32'hFFFF_FFFF)
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (r_state == S_IDLE && w_req && !w_hit && r_miss_cnt != 32'hFFFF_FFFF)
            r_miss_cnt <= r_miss_cnt + 32'd1;
         if (r_state == S_ALLOC && w_ack && w_last) r_after_miss <= 1'b1;
         else if (r_state == S_IDLE)                r_after_miss <= 1'b0;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_otter_dcache.sv
// ============================================================================
// tb_otter_dcache : scoreboard bench for otter_dcache against a flat-memory model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_otter_dcache;
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   otter_dcache_if bus();
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   otter_dcache #(.LINES(16), .WORDS(4)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count(hit_count),
      .miss_count(miss_count)
`endif
   );

   typedef struct {
      bit          is_load;
      logic [31:0] data;
      int          acks;
      int          ack_start;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0, passes = 0;
   int          ack_total = 0, stable_bad = 0, viol = 0;
   int          min_delay = 0, max_delay = 0;
   int          misses = 0, hits = 0;
   bit          req_active = 0, sb_done = 0, sb_en = 1;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bk_mem  [logic [31:0]];
   bit          m_valid [16];
   bit          m_dirty [16];
   logic [23:0] m_tag   [16];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic summary();
      $display("%0d/%0d checks passed", passes, checks);
   endtask

   function automatic logic [31:0] init_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] rd_ref(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rd_bk(logic [31:0] a);
      return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ld_expect(logic [31:0] w, logic [31:0] a, logic [1:0] sz, bit zx);
      logic [31:0] v;
      case (sz)
         2'd0: begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!zx && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!zx && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] st_merge(logic [31:0] old, logic [31:0] a, logic [1:0] sz, logic [31:0] din);
      logic [31:0] mask, val;
      case (sz)
         2'd0: begin
            mask = 32'hFF << (8 * a[1:0]);
            val  = (din & 32'hFF) << (8 * a[1:0]);
         end
         2'd1: begin
            mask = 32'hFFFF << (16 * a[1]);
            val  = (din & 32'hFFFF) << (16 * a[1]);
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            val  = din;
         end
      endcase
      return (old & ~mask) | (val & mask);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         m_tag[i]   = '0;
      end
      ref_mem = bk_mem;
      misses  = 0;
      hits    = 0;
   endtask

   // Issue one request at posedge+1 and hold it until the monitor sees it complete
   task automatic issue(bit st, logic [31:0] a, logic [1:0] sz, bit zx, logic [31:0] din);
      exp_t        e;
      int          idx;
      logic [23:0] t;
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      idx = int'(a[7:4]);
      t = a[31:8];
      e.is_load   = !st;
      e.ack_start = ack_total;
      if (m_valid[idx] && m_tag[idx] == t) begin
         e.acks = 0;
         hits++;
      end else begin
         e.acks = (m_valid[idx] && m_dirty[idx]) ? 8 : 4;
         m_valid[idx] = 1;
         m_tag[idx]   = t;
         m_dirty[idx] = 0;
         misses++;
      end
      if (st) begin
         m_dirty[idx] = 1;
         ref_mem[wa]  = st_merge(rd_ref(wa), a, sz, din);
         e.data       = 32'd0;
      end else begin
         e.data = ld_expect(rd_ref(wa), a, sz, zx);
      end
      sbq.push_back(e);
      bus.MEM_WE2   = st;
      bus.MEM_RDEN2 = !st;
      bus.MEM_ADDR2 = a;
      bus.MEM_SIZE  = sz;
      bus.MEM_SIGN  = zx;
      bus.MEM_DIN2  = din;
      sb_done       = 0;
      req_active    = 1;
      for (int c = 0; c < 400 && !sb_done; c++) @(posedge CLK);
      if (!sb_done) begin
         checks++;
         $display("FAIL request_timeout: addr %h never completed", a);
         summary();
         $finish;
      end
      #1;
      bus.MEM_WE2   = 0;
      bus.MEM_RDEN2 = 0;
      req_active    = 0;
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports completion
   always @(negedge CLK) begin
      exp_t e;
      if (bus.mem_req && bus.memValid2) viol++;
      if (sb_en && req_active && !sb_done && bus.memValid2) begin
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL sb_empty: completion with no expected entry");
         end else begin
            e = sbq.pop_front();
            if (e.is_load) chk("load_data", bus.MEM_DOUT2, e.data);
            chk("ack_count", ack_total - e.ack_start, e.acks);
         end
         sb_done = 1;
      end
   end

   // Backing memory with random per-word latency
   initial begin
      bit          busy;
      int          wait_left;
      logic [31:0] r_addr;
      busy = 0;
      wait_left = 0;
      r_addr = '0;
      bus.mem_ack   = 0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge CLK);
         #1;
         bus.mem_ack = 0;
         if (bus.mem_req !== 1'b1) begin
            busy = 0;
         end else begin
            if (!busy) begin
               busy      = 1;
               r_addr    = bus.mem_addr;
               wait_left = $urandom_range(max_delay, min_delay);
            end else if (bus.mem_addr !== r_addr) begin
               stable_bad++;
            end
            if (wait_left == 0) begin
               bus.mem_ack = 1;
               ack_total++;
               busy = 0;
               if (bus.mem_we) begin
                  chk("wb_data", bus.mem_wdata, rd_ref(r_addr));
                  bk_mem[r_addr] = bus.mem_wdata;
               end else begin
                  bus.mem_rdata = rd_bk(r_addr);
               end
            end else begin
               wait_left--;
            end
         end
      end
   end

   initial begin
      int start;
      RESET = 1;
      bus.MEM_RDEN2 = 0;
      bus.MEM_WE2   = 0;
      bus.MEM_ADDR2 = '0;
      bus.MEM_DIN2  = '0;
      bus.MEM_SIZE  = 2'd2;
      bus.MEM_SIGN  = 0;
      ref_mem[32'h100] = 32'h80FF_7F01;
      bk_mem[32'h100]  = 32'h80FF_7F01;
      ref_mem[32'h104] = 32'hDEAD_BEEF;
      bk_mem[32'h104]  = 32'hDEAD_BEEF;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_valid", {31'd0, bus.memValid2}, 32'd1);
      chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("reset_dout", bus.MEM_DOUT2, 32'd0);
      chk("reset_mem_addr", bus.mem_addr, 32'd0);
      RESET = 0;
      @(posedge CLK);
      #1;

      issue(0, 32'h104, 2'd2, 0, 0);             // cold load, 4 reads
      issue(0, 32'h103, 2'd0, 0, 0);             // LB  -> FFFFFF80
      issue(0, 32'h103, 2'd0, 1, 0);             // LBU -> 00000080
      issue(0, 32'h102, 2'd1, 0, 0);             // LH  -> FFFF80FF
      issue(1, 32'h101, 2'd0, 0, 32'h5A);        // SB hit
      issue(0, 32'h100, 2'd2, 0, 0);             // -> 80FF5A01
      chk("merge_literal", rd_ref(32'h100), 32'h80FF_5A01);
      issue(0, 32'h500, 2'd2, 0, 0);             // dirty eviction: 8 acks
      issue(0, 32'h100, 2'd2, 0, 0);             // victim 0x500 clean: 4 acks
      issue(0, 32'h500, 2'd2, 0, 0);             // 0x100 was cleaned: 4 acks

      // Reset in the middle of a refill
      sb_en = 0;
      start = ack_total;
      bus.MEM_ADDR2 = 32'h900;
      bus.MEM_SIZE  = 2'd2;
      bus.MEM_RDEN2 = 1;
      req_active    = 1;
      for (int c = 0; c < 200 && (ack_total - start) < 2; c++) @(posedge CLK);
      chk("rst_test_acks", ack_total - start, 32'd2);
      #2;
      RESET = 1;
      bus.MEM_RDEN2 = 0;
      req_active = 0;
      #1;
      chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("midrst_valid", {31'd0, bus.memValid2}, 32'd1);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RESET = 0;
      sb_en = 1;
      issue(0, 32'h900, 2'd2, 0, 0);             // full refill again

      // Backpressure
      min_delay = 5;
      max_delay = 5;
      issue(0, 32'h2C8, 2'd2, 0, 0);
      issue(1, 32'h2C4, 2'd1, 0, 32'hBEEF);
      issue(0, 32'h6C4, 2'd2, 0, 0);
      issue(0, 32'h2C6, 2'd1, 1, 0);

      // Random traffic over a small footprint to force hits and conflicts
      min_delay = 0;
      max_delay = 3;
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
         issue(($urandom_range(0, 9) < 4), a, 2'($urandom), 1'($urandom), $urandom);
      end

      chk("valid_low_during_req", viol, 32'd0);
      chk("addr_stable", stable_bad, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("miss_count", miss_count, misses);
      chk("hit_count", hit_count, hits);
`endif
      summary();
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      summary();
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
